cby_cfg_chan: RTL

Parametrised vertical connection block, the configurable successor to the fixed `cby_*` pass-through blocks. It carries CHAN_WIDTH routing tracks in each direction and drives NUM_IPIN logic-block input pins through configurable track muxes. Selects are loaded over a configuration flip-flop chain and applied atomically through a shadow register. The block sits between vertically adjacent switch boxes in the routing fabric.

---
 rtl/cby_pkg.sv | 30 +++
 rtl/cby_ccff_chain.sv | 59 +++++
 rtl/cby_cfg_chan.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cby_pkg.sv
// ----------------------------------------------------------------------------
// cby_pkg
// Shared constants and sizing helpers for the configurable connection blocks.
//   SEL_CONST0 : select value that drives a logic-block input pin to 0.
//   sel_w()    : per-pin select width for a channel of chan_width tracks.
//   cfg_len()  : total configuration chain length.
// ----------------------------------------------------------------------------
package cby_pkg;

    localparam int SEL_CONST0 = 0;

    // Width needed to encode 0 (constant), CHAN_WIDTH bottom tracks and
    // CHAN_WIDTH top tracks, i.e. ceil(log2(2*chan_width+1)).
    function automatic int sel_w(input int chan_width);
        int w;
        w = 0;
        while ((1 << w) < (2 * chan_width + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Pin selects first; with track registers enabled, one enable bit per
    // track per direction follows the pin selects.
    function automatic int cfg_len(input int chan_width, input int num_ipin,
                                   input bit reg_en);
        return num_ipin * sel_w(chan_width) + (reg_en ? 2 * chan_width : 0);
    endfunction

endpackage

// File: rtl/cby_ccff_chain.sv
// ----------------------------------------------------------------------------
// cby_ccff_chain
// Configuration flip-flop chain with a shadow register. Bits are shifted in
// at ccff_head while cfg_en is high; after CFG_LEN enabled edges the shifted
// word is copied atomically into 'active' and cfg_valid is raised. Pausing
// cfg_en holds the partial load. The first bit shifted lands at CFG_LEN-1.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   cfg_en     in   shift enable
//   ccff_head  in   chain serial input
//   ccff_tail  out  chain serial output (chain MSB)
//   cfg_valid  out  a complete configuration has been applied
//   active     out  CFG_LEN-bit committed configuration
// ----------------------------------------------------------------------------
module cby_ccff_chain #(
    parameter int CFG_LEN = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_en,
    input  logic               ccff_head,
    output logic               ccff_tail,
    output logic               cfg_valid,
    output logic [CFG_LEN-1:0] active
);

    localparam int CNT_W = (CFG_LEN > 1) ? $clog2(CFG_LEN) : 1;

    logic [CFG_LEN-1:0] chain_q;
    logic [CFG_LEN-1:0] chain_next;
    logic [CNT_W-1:0]   cnt;
    logic               load_done;

    assign chain_next = {chain_q[CFG_LEN-2:0], ccff_head};
    assign load_done  = cfg_en && (cnt == CNT_W'(CFG_LEN - 1));
    assign ccff_tail  = chain_q[CFG_LEN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q   <= '0;
            cnt       <= '0;
            active    <= '0;
            cfg_valid <= 1'b0;
        end else if (cfg_en) begin
            chain_q <= chain_next;
            if (load_done) begin
                // Commit the word including the bit entering on this edge.
                active    <= chain_next;
                cnt       <= '0;
                cfg_valid <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cby_cfg_chan.sv
// ----------------------------------------------------------------------------
// cby_cfg_chan
// Configurable vertical connection block. Passes CHAN_WIDTH tracks in each
// direction and drives NUM_IPIN registered logic-block input pins, each
// through a track mux whose select is loaded over a configuration chain.
//
// Compile-time option:
//   CBY_TRACK_REG_EN  when defined, each pass-through track gets a register
//                     that is selected by its own configuration bit.
//
// Ports:
//   clk               in   clock for chain and datapath registers
//   rst_n             in   asynchronous active-low reset
//   cfg_en            in   config chain shift enable
//   ccff_head         in   config chain serial input
//   ccff_tail         out  config chain serial output
//   cfg_valid         out  a complete configuration has been applied
//   chany_bottom_in   in   tracks entering from below
//   chany_top_in      in   tracks entering from above
//   chany_top_out     out  tracks leaving upward   (from chany_bottom_in)
//   chany_bottom_out  out  tracks leaving downward (from chany_top_in)
//   ipin_out          out  registered input-pin drives
// ----------------------------------------------------------------------------
module cby_cfg_chan
    import cby_pkg::*;
#(
    parameter int CHAN_WIDTH = 9,
    parameter int NUM_IPIN   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic                  ccff_head,
    output logic                  ccff_tail,
    output logic                  cfg_valid,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [CHAN_WIDTH-1:0] chany_top_in,
    output logic [CHAN_WIDTH-1:0] chany_top_out,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic [NUM_IPIN-1:0]   ipin_out
);

`ifdef CBY_TRACK_REG_EN
    localparam bit TRACK_REG_EN = 1'b1;
`else
    localparam bit TRACK_REG_EN = 1'b0;
`endif

    localparam int SEL_W    = sel_w(CHAN_WIDTH);
    localparam int PIN_BITS = NUM_IPIN * SEL_W;
    localparam int CFG_LEN  = cfg_len(CHAN_WIDTH, NUM_IPIN, TRACK_REG_EN);
    localparam int CAND_W   = 2 * CHAN_WIDTH + 1;

    logic [CFG_LEN-1:0]  active;
    logic [CAND_W-1:0]   cand;
    logic [NUM_IPIN-1:0] mux_p0;
    logic [NUM_IPIN-1:0] ipin_p1;

    cby_ccff_chain #(
        .CFG_LEN (CFG_LEN)
    ) u_chain (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .ccff_head (ccff_head),
        .ccff_tail (ccff_tail),
        .cfg_valid (cfg_valid),
        .active    (active)
    );

    // Candidate vector indexed directly by the select: bit 0 is the constant
    // zero, bits 1..CW are bottom tracks, bits CW+1..2*CW are top tracks.
    assign cand = {chany_top_in, chany_bottom_in, 1'b0};

    // Stage p0: pin muxes
    for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
        logic [SEL_W-1:0] sel;
        assign sel = active[k*SEL_W +: SEL_W];
        always_comb begin
            mux_p0[k] = 1'b0;
            if (sel == SEL_W'(SEL_CONST0)) begin
                mux_p0[k] = 1'b0;
            end else if (sel <= SEL_W'(2 * CHAN_WIDTH)) begin
                mux_p0[k] = cand[sel];
            end
        end
    end

    // Stage p1: registered pin drives, held at 0 until a config is applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ipin_p1 <= '0;
        end else begin
            ipin_p1 <= cfg_valid ? mux_p0 : '0;
        end
    end

    assign ipin_out = ipin_p1;

`ifdef CBY_TRACK_REG_EN
    logic [CHAN_WIDTH-1:0] top_reg_p1;
    logic [CHAN_WIDTH-1:0] bot_reg_p1;
    logic [CHAN_WIDTH-1:0] top_reg_en;
    logic [CHAN_WIDTH-1:0] bot_reg_en;

    assign top_reg_en = active[PIN_BITS +: CHAN_WIDTH];
    assign bot_reg_en = active[PIN_BITS + CHAN_WIDTH +: CHAN_WIDTH];

    // Stage p1: optional track registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_reg_p1 <= '0;
            bot_reg_p1 <= '0;
        end else begin
            top_reg_p1 <= chany_bottom_in;
            bot_reg_p1 <= chany_top_in;
        end
    end

    // Per-track choice between registered and combinational path.
    assign chany_top_out    = (top_reg_en & top_reg_p1) | (~top_reg_en & chany_bottom_in);
    assign chany_bottom_out = (bot_reg_en & bot_reg_p1) | (~bot_reg_en & chany_top_in);
`else
    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;
`endif

endmodule
